// File: rtl/demux_sched_1x8.sv
// demux_sched_1x8: sequencing controller for the 1-to-8 demux datapath.
// It accepts one valid/ready input beat at a time and picks a destination
// channel, either from in_dest (addressed mode) or by round-robin over the
// enabled channels. The chosen beat is held in a registered one-hot output
// stage until that channel's consumer takes it.
module demux_sched_1x8 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [7:0]        chan_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_dest,
    output logic              in_ready,
    output logic [7:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [7:0]        out_ready,
    output logic [2:0]        sel,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  sel_q;
    logic [2:0]  rr_ptr;
    logic [2:0]  rr_target;
    logic [2:0]  rr_idx;
    logic        rr_found;
    logic [2:0]  target;
    logic        target_ok;
    logic        accept;
    logic        handshake;

    // Round-robin search: first enabled channel at or after rr_ptr, wrapping 7 -> 0.
    always_comb begin
        rr_target = rr_ptr;
        rr_found  = 1'b0;
        rr_idx    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            rr_idx = rr_ptr + 3'(k);
            if (!rr_found && chan_en[rr_idx]) begin
                rr_target = rr_idx;
                rr_found  = 1'b1;
            end
        end
    end

    // Readiness, acceptance and target selection; in_ready is combinational from out_ready.
    always_comb begin
        handshake = (state == SEND) && out_ready[sel_q];
        in_ready  = ((state == IDLE) || out_ready[sel_q]) && !(mode && (chan_en == 8'd0));
        accept    = in_valid && in_ready;
        target    = mode ? rr_target : in_dest;
        target_ok = chan_en[target];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a handshake with a fresh enabled beat keeps SEND for back-to-back flow.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && target_ok) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    state_nxt = (accept && target_ok) ? SEND : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat holding register, round-robin pointer and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            sel_q    <= 3'd0;
            rr_ptr   <= 3'd0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (target_ok) begin
                out_data <= in_data;
                sel_q    <= target;
            end else if (!mode && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (mode) begin
                rr_ptr <= target + 3'd1;
            end
        end
    end

    // Outputs decoded from registered state, so out_valid is one-hot or zero by construction.
    always_comb begin
        out_valid = 8'd0;
        sel       = 3'd0;
        busy      = 1'b0;
        if (state == SEND) begin
            out_valid = 8'd1 << sel_q;
            sel       = sel_q;
            busy      = 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_sched_1x8.sv
// Directed testbench for demux_sched_1x8. A second instance with a 2-bit
// drop counter shares the same stimulus to exercise counter saturation.
module tb_demux_sched_1x8;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [7:0] chan_en;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_dest;
    logic [7:0] out_ready;

    logic       in_ready;
    logic [7:0] out_valid;
    logic [7:0] out_data;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] drop_cnt;

    logic       in_ready_b;
    logic [7:0] out_valid_b;
    logic [7:0] out_data_b;
    logic [2:0] sel_b;
    logic       busy_b;
    logic [1:0] drop_cnt_b;

    int n_checks;
    int n_fail;

    demux_sched_1x8 #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .chan_en(chan_en),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .sel(sel), .busy(busy), .drop_cnt(drop_cnt)
    );

    demux_sched_1x8 #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .chan_en(chan_en),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ready(out_ready), .sel(sel_b), .busy(busy_b), .drop_cnt(drop_cnt_b)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; chan_en = 8'h00; in_valid = 1'b0;
        in_data = 8'h00; in_dest = 3'd0; out_ready = 8'h00;
        #12;
        n_checks++;
        if ({out_valid, out_data, sel, busy, drop_cnt} !== 28'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got ov=%h od=%h sel=%0d busy=%b drop=%0d, expected all zero",
                     out_valid, out_data, sel, busy, drop_cnt);
        end
        n_checks++;
        if ({out_valid_b, out_data_b, sel_b, busy_b, drop_cnt_b} !== 22'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs_sat: got ov=%h od=%h sel=%0d busy=%b drop=%0d, expected all zero",
                     out_valid_b, out_data_b, sel_b, busy_b, drop_cnt_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || in_ready_b !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready: got %b/%b, expected 1/1", in_ready, in_ready_b);
        end
    endtask

    task automatic test_addressed();
        logic [7:0] exp_ov;
        mode = 1'b0; chan_en = 8'hFF; out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'hD0 + 8'(i); in_dest = 3'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL addr_in_ready[%0d]: got %b, expected 1", i, in_ready);
            end
            @(posedge clk); #1;
            exp_ov = 8'(1 << i);
            n_checks++;
            if (out_valid !== exp_ov || out_data !== 8'hD0 + 8'(i) || sel !== 3'(i) || busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL addr_beat[%0d]: got ov=%h od=%h sel=%0d busy=%b, expected ov=%h od=%h sel=%0d busy=1",
                         i, out_valid, out_data, sel, busy, exp_ov, 8'hD0 + 8'(i), i);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 8'h00 || busy !== 1'b0 || sel !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL addr_idle: got ov=%h busy=%b sel=%0d, expected ov=00 busy=0 sel=0",
                     out_valid, busy, sel);
        end
    endtask

    task automatic test_drop();
        mode = 1'b0; chan_en = 8'hFE; out_ready = 8'hFF; in_dest = 3'd0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'hE0 + 8'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL drop_in_ready[%0d]: got %b, expected 1", i, in_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 8'h00 || busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL drop_no_out[%0d]: got ov=%h busy=%b, expected ov=00 busy=0",
                         i, out_valid, busy);
            end
            if (i == 2) begin
                n_checks++;
                if (drop_cnt !== 8'd3 || drop_cnt_b !== 2'd3) begin
                    n_fail++;
                    $display("[TB] FAIL drop_cnt_3: got %0d/%0d, expected 3/3", drop_cnt, drop_cnt_b);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (drop_cnt !== 8'd5 || drop_cnt_b !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL drop_saturate: got %0d/%0d, expected 5/3", drop_cnt, drop_cnt_b);
        end
    endtask

    task automatic test_round_robin();
        int exp_ch [6] = '{0, 2, 5, 7, 0, 2};
        mode = 1'b1; chan_en = 8'hA5; out_ready = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            int ch;
            if (i == 6) chan_en = 8'hFF;
            ch = (i == 6) ? 3 : exp_ch[i];
            in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL rr_in_ready[%0d]: got %b, expected 1", i, in_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 8'(1 << ch) || sel !== 3'(ch) || out_data !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("[TB] FAIL rr_beat[%0d]: got ov=%h sel=%0d od=%h, expected ov=%h sel=%0d od=%h",
                         i, out_valid, sel, out_data, 8'(1 << ch), ch, 8'hA0 + 8'(i));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        mode = 1'b0; chan_en = 8'hFF; out_ready = 8'hEF;
        in_valid = 1'b1; in_data = 8'h5A; in_dest = 3'd4;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_first_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_data = 8'hC3; in_dest = 3'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 8'h10 || out_data !== 8'h5A || sel !== 3'd4 || in_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL bp_hold[%0d]: got ov=%h od=%h sel=%0d rdy=%b, expected ov=10 od=5a sel=4 rdy=0",
                         i, out_valid, out_data, sel, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 8'hFF;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_release_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 8'h02 || out_data !== 8'hC3 || sel !== 3'd1) begin
            n_fail++;
            $display("[TB] FAIL bp_next_beat: got ov=%h od=%h sel=%0d, expected ov=02 od=c3 sel=1",
                     out_valid, out_data, sel);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rr_stall();
        mode = 1'b1; chan_en = 8'h00; out_ready = 8'hFF;
        in_valid = 1'b1; in_data = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL rr_stall[%0d]: got rdy=%b ov=%h, expected rdy=0 ov=00",
                         i, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        chan_en = 8'h08;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rr_resume_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 8'h08 || sel !== 3'd3 || out_data !== 8'h3C) begin
            n_fail++;
            $display("[TB] FAIL rr_resume_beat: got ov=%h sel=%0d od=%h, expected ov=08 sel=3 od=3c",
                     out_valid, sel, out_data);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_send();
        mode = 1'b0; chan_en = 8'hFF; out_ready = 8'h00;
        in_valid = 1'b1; in_data = 8'h66; in_dest = 3'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 8'h20 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_setup: got ov=%h busy=%b, expected ov=20 busy=1", out_valid, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_data, sel, busy, drop_cnt} !== 28'h0 || drop_cnt_b !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_async: got ov=%h od=%h sel=%0d busy=%b drop=%0d/%0d, expected all zero",
                     out_valid, out_data, sel, busy, drop_cnt, drop_cnt_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode = 1'b1; chan_en = 8'hFF; out_ready = 8'hFF;
        in_valid = 1'b1; in_data = 8'h99;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_after_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 8'h01 || sel !== 3'd0 || out_data !== 8'h99) begin
            n_fail++;
            $display("[TB] FAIL rst_after_rr: got ov=%h sel=%0d od=%h, expected ov=01 sel=0 od=99",
                     out_valid, sel, out_data);
        end
        @(posedge clk); #1;
    endtask

    // Scenario sequence and summary.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_addressed();
        test_drop();
        test_round_robin();
        test_backpressure();
        test_rr_stall();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
